// File: rtl/mem_pkg.sv
// mem_pkg: size and state codes shared by the byte-addressable memory controller.
package mem_pkg;
   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
   typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_e;
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction
endpackage

// File: rtl/mem_lane_sel.sv
// mem_lane_sel: maps an access onto byte lanes; lane k carries data bits [8k+7:8k].
module mem_lane_sel
   import mem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 32,
   parameter int ALIGN_CHECK = 0
) (
   input  logic [ADDR_W-1:0]                         addr,
   input  logic [1:0]                                size,
   output logic [DATA_W/8-1:0][$clog2(DEPTH)-1:0]    idx,
   output logic [DATA_W/8-1:0]                       en,
   output logic                                      err
);
   localparam int NB = DATA_W / 8;
   localparam int AW = $clog2(DEPTH);
   logic [3:0] n;
   logic [2:0] lo_mask;
   always_comb begin
      n       = size_bytes(size);
      lo_mask = 3'(n - 4'd1);
      err     = (addr >= ADDR_W'(DEPTH)) || (size == SZ_D && DATA_W == 32) ||
                (ALIGN_CHECK != 0 && (addr[2:0] & lo_mask) != 3'd0);
      // big-endian: the lowest data byte lands at the highest address of the access
      for (int k = 0; k < NB; k++) begin
         en[k]  = 4'(k) < n;
         idx[k] = addr[AW-1:0] + AW'(n - 4'd1 - 4'(k));
      end
   end
endmodule

// File: rtl/byte_mem_ctrl.sv
// byte_mem_ctrl: byte-addressable big-endian data memory with clear sweep and registered response.
module byte_mem_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 32,
   parameter int ALIGN_CHECK = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   output logic              busy,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);
   localparam int NB    = DATA_W / 8;
   localparam int AW    = $clog2(DEPTH);
   localparam int WORDS = DEPTH / NB;
   localparam int PW    = WORDS > 1 ? $clog2(WORDS) : 1;
   localparam int LW    = $clog2(NB);
   logic [7:0]               mem [DEPTH];
   state_e                   state, state_nxt;
   logic [PW-1:0]            ptr, ptr_nxt;
   logic [NB-1:0][AW-1:0]    idx;
   logic [NB-1:0]            en;
   logic                     err, acc;
   logic [DATA_W-1:0]        rd;

   mem_lane_sel #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ALIGN_CHECK(ALIGN_CHECK)
   ) u_sel (
      .addr(req_addr), .size(req_size), .idx(idx), .en(en), .err(err)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= ST_CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      busy      = state == ST_CLEAR;
      req_ready = state == ST_IDLE && !clr_req;
      acc       = req_valid && req_ready;
      if (clr_req) begin
         state_nxt = ST_CLEAR;
         ptr_nxt   = '0;
      end else if (busy) begin
         ptr_nxt   = ptr == PW'(WORDS - 1) ? '0 : ptr + PW'(1);
         state_nxt = ptr == PW'(WORDS - 1) ? ST_IDLE : ST_CLEAR;
      end
   end

   always_comb begin
      rd = '0;
      for (int k = 0; k < NB; k++)
         if (en[k]) rd[8*k +: 8] = mem[idx[k]];
   end

   // array is cleared by the sweep, so it carries no reset
   always_ff @(posedge clk)
      if (busy) begin
         for (int k = 0; k < NB; k++) mem[AW'({ptr, LW'(k)})] <= '0;
      end else if (acc && req_we && !err) begin
         for (int k = 0; k < NB; k++)
            if (en[k]) mem[idx[k]] <= req_wdata[8*k +: 8];
      end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= acc;
         rsp_err   <= acc && err;
         rsp_rdata <= (acc && !req_we && !err) ? rd : '0;
      end
endmodule

// File: tb/tb_byte_mem_ctrl.sv
// tb_byte_mem_ctrl: random and directed checks of two instances (unaligned allowed / rejected) against a byte-array model.
module tb_byte_mem_ctrl;
   logic        clk = 0, rst = 0, clr_req = 0, req_valid = 0, req_we = 0;
   logic [1:0]  req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        busy [2], ready [2], rv [2], re [2];
   logic [31:0] rd [2];
   logic        got_v [2], got_e [2], exp_e [2];
   logic [31:0] got_d [2], exp_d [2];
   logic [7:0]  m [2][16];
   int          checks = 0, errors = 0;
   int          c [2];

   always #5 clk = ~clk;

   byte_mem_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .ALIGN_CHECK(0)) u_dut0 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy[0]), .req_valid(req_valid),
      .req_ready(ready[0]), .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]));

   byte_mem_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .ALIGN_CHECK(1)) u_dut1 (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy[1]), .req_valid(req_valid),
      .req_ready(ready[1]), .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]));

   // byte i of an N-byte access lives at (addr+i) mod 16, most significant byte first
   function automatic void model(input int ac, input logic we, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic e, output logic [31:0] r);
      int n;
      logic [3:0] bi;
      n = 1 << sz;
      e = (a >= 32'd16) || (sz == 2'd3) || (ac == 1 && (a % 32'(n)) != 0);
      r = '0;
      if (!e)
         for (int i = 0; i < n; i++) begin
            bi = 4'(a + 32'(i));
            if (we) m[ac][bi] = 8'(wd >> (8 * (n - 1 - i)));
            else r = (r << 8) | 32'(m[ac][bi]);
         end
   endfunction

   function automatic void zero_model();
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 16; j++) m[i][j] = '0;
   endfunction

   task automatic issue(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
      for (int k = 0; k < 2; k++) model(k, we, sz, a, wd, exp_e[k], exp_d[k]);
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         got_v[k] = rv[k]; got_e[k] = re[k]; got_d[k] = rd[k];
      end
   endtask

   task automatic count_busy(output int c0, output int c1);
      c0 = 0; c1 = 0;
      repeat (12) begin
         @(negedge clk);
         if (busy[0]) c0++;
         if (busy[1]) c1++;
      end
   endtask

   task automatic test_reset();
      zero_model();
      rst = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (rv[k] !== 0 || rd[k] !== 0 || re[k] !== 0 || busy[k] !== 1 || ready[k] !== 0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: v=%b d=%h e=%b busy=%b ready=%b, expected 0 0 0 1 0", k, rv[k], rd[k], re[k], busy[k], ready[k]);
         end
      end
      rst = 1;
      count_busy(c[0], c[1]);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (c[k] !== 4 || ready[k] !== 1) begin
            errors++;
            $display("FAIL initial_sweep dut%0d: busy cycles %0d ready=%b, expected 4 and 1", k, c[k], ready[k]);
         end
      end
      issue(0, 2, 0, 0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_v[k] !== 1 || got_e[k] !== 0 || got_d[k] !== 32'h0) begin
            errors++;
            $display("FAIL read_after_clear dut%0d: v=%b e=%b d=%h, expected 1 0 00000000", k, got_v[k], got_e[k], got_d[k]);
         end
      end
      req_valid = 0;
   endtask

   task automatic test_basic();
      logic [1:0]  sz [3]   = '{2'd0, 2'd1, 2'd2};
      logic [31:0] ad [3]   = '{32'd5, 32'd6, 32'd4};
      logic [31:0] want [3] = '{32'h000000AD, 32'h0000BEEF, 32'hDEADBEEF};
      issue(1, 2, 4, 32'hDEADBEEF);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_v[k] !== 1 || got_e[k] !== 0 || got_d[k] !== 0) begin
            errors++;
            $display("FAIL write_word dut%0d: v=%b e=%b d=%h, expected 1 0 00000000", k, got_v[k], got_e[k], got_d[k]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         issue(0, sz[i], ad[i], 0);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_v[k] !== 1 || got_e[k] !== 0 || got_d[k] !== want[i]) begin
               errors++;
               $display("FAIL big_endian_read%0d dut%0d: v=%b e=%b d=%h, expected 1 0 %h", i, k, got_v[k], got_e[k], got_d[k], want[i]);
            end
         end
      end
      req_valid = 0;
   endtask

   task automatic test_wrap();
      issue(1, 2, 14, 32'h11223344);
      issue(0, 2, 0, 0);
      checks++;
      if (got_d[0] !== 32'h33440000 || got_e[0] !== 0) begin
         errors++;
         $display("FAIL wrap_word dut0: e=%b d=%h, expected 0 33440000", got_e[0], got_d[0]);
      end
      checks++;
      if (got_d[1] !== exp_d[1] || got_e[1] !== exp_e[1]) begin
         errors++;
         $display("FAIL wrap_word dut1: e=%b d=%h, expected %b %h", got_e[1], got_d[1], exp_e[1], exp_d[1]);
      end
      issue(0, 1, 14, 0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_v[k] !== 1 || got_e[k] !== exp_e[k] || got_d[k] !== exp_d[k] || (k == 0 && got_d[k] !== 32'h00001122)) begin
            errors++;
            $display("FAIL wrap_half dut%0d: v=%b e=%b d=%h, expected 1 %b %h", k, got_v[k], got_e[k], got_d[k], exp_e[k], exp_d[k]);
         end
      end
      req_valid = 0;
   endtask

   task automatic test_errors();
      logic [31:0] bad [4] = '{32'd16, 32'd17, 32'd255, 32'hFFFFFFFC};
      issue(1, 2, 2, $urandom);
      checks++;
      if (got_e[1] !== 1 || got_d[1] !== 0 || got_e[0] !== 0) begin
         errors++;
         $display("FAIL misaligned_word: err0=%b err1=%b d1=%h, expected 0 1 00000000", got_e[0], got_e[1], got_d[1]);
      end
      issue(0, 2, 4, 0);
      checks++;
      if (got_d[1] !== 32'hDEADBEEF || got_d[0] !== exp_d[0]) begin
         errors++;
         $display("FAIL misaligned_no_write: d0=%h d1=%h, expected %h DEADBEEF", got_d[0], got_d[1], exp_d[0]);
      end
      for (int i = 0; i < 4; i++)
         for (int s = 0; s < 3; s++) begin
            issue(1'($urandom), 2'(s), bad[i], $urandom);
            for (int k = 0; k < 2; k++) begin
               checks++;
               if (got_v[k] !== 1 || got_e[k] !== 1 || got_d[k] !== 0) begin
                  errors++;
                  $display("FAIL out_of_range a=%h s=%0d dut%0d: v=%b e=%b d=%h, expected 1 1 00000000", bad[i], s, k, got_v[k], got_e[k], got_d[k]);
               end
            end
         end
      for (int w = 0; w < 2; w++) begin
         issue(1'(w), 3, 8, $urandom);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_v[k] !== 1 || got_e[k] !== 1 || got_d[k] !== 0) begin
               errors++;
               $display("FAIL size3 we=%0d dut%0d: v=%b e=%b d=%h, expected 1 1 00000000", w, k, got_v[k], got_e[k], got_d[k]);
            end
         end
      end
      req_valid = 0;
   endtask

   task automatic test_random();
      logic        we;
      logic [1:0]  sz;
      logic [31:0] a;
      for (int i = 0; i < 150; i++) begin
         we = 1'($urandom);
         sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = ($urandom % 10 == 0) ? $urandom : 32'($urandom_range(0, 15));
         issue(we, sz, a, $urandom);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_v[k] !== 1 || got_e[k] !== exp_e[k] || got_d[k] !== exp_d[k]) begin
               errors++;
               $display("FAIL random#%0d we=%b s=%0d a=%h dut%0d: v=%b e=%b d=%h, expected 1 %b %h", i, we, sz, a, k, got_v[k], got_e[k], got_d[k], exp_e[k], exp_d[k]);
            end
         end
      end
      req_valid = 0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] last = 0, wd;
      logic        we;
      for (int i = 0; i < 20; i++) begin
         we = (i % 2 == 0);
         wd = $urandom;
         issue(we, 2, 8, wd);
         if (we) last = wd;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_v[k] !== 1 || got_e[k] !== 0 || got_d[k] !== (we ? 32'h0 : last)) begin
               errors++;
               $display("FAIL back_to_back#%0d dut%0d: v=%b e=%b d=%h, expected 1 0 %h", i, k, got_v[k], got_e[k], got_d[k], we ? 32'h0 : last);
            end
         end
      end
      req_valid = 0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (rv[k] !== 0) begin
            errors++;
            $display("FAIL rsp_valid_drop dut%0d: v=%b, expected 0", k, rv[k]);
         end
      end
   endtask

   task automatic test_clear();
      issue(1, 2, 8, 32'hCAFEF00D);
      @(negedge clk);
      req_valid = 1; req_we = 1; req_size = 2; req_addr = 0; req_wdata = 32'hFFFFFFFF; clr_req = 1;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (ready[k] !== 0) begin
            errors++;
            $display("FAIL clr_wins_ready dut%0d: ready=%b, expected 0", k, ready[k]);
         end
      end
      @(posedge clk);
      #1;
      clr_req = 0; req_valid = 0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (rv[k] !== 0) begin
            errors++;
            $display("FAIL clr_no_accept dut%0d: v=%b, expected 0", k, rv[k]);
         end
      end
      count_busy(c[0], c[1]);
      zero_model();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (c[k] !== 4) begin
            errors++;
            $display("FAIL clr_sweep dut%0d: busy cycles %0d, expected 4", k, c[k]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         issue(0, 2, 32'(4 * i), 0);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_v[k] !== 1 || got_e[k] !== 0 || got_d[k] !== 0) begin
               errors++;
               $display("FAIL cleared_read a=%0d dut%0d: v=%b e=%b d=%h, expected 1 0 00000000", 4 * i, k, got_v[k], got_e[k], got_d[k]);
            end
         end
      end
      req_valid = 0;
      @(negedge clk) clr_req = 1;
      @(posedge clk);
      #1 clr_req = 0;
      @(negedge clk);
      @(negedge clk) clr_req = 1;
      @(posedge clk);
      #1 clr_req = 0;
      count_busy(c[0], c[1]);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (c[k] !== 4) begin
            errors++;
            $display("FAIL clr_restart dut%0d: busy cycles after restart %0d, expected 4", k, c[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      issue(1, 2, 12, 32'h5A5AA5A5);
      issue(0, 2, 12, 0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_v[k] !== 1 || got_d[k] !== 32'h5A5AA5A5) begin
            errors++;
            $display("FAIL pre_reset_read dut%0d: v=%b d=%h, expected 1 5a5aa5a5", k, got_v[k], got_d[k]);
         end
      end
      rst = 0;
      req_valid = 0;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (rv[k] !== 0 || rd[k] !== 0 || re[k] !== 0 || busy[k] !== 1 || ready[k] !== 0) begin
            errors++;
            $display("FAIL reset_mid_response dut%0d: v=%b d=%h e=%b busy=%b ready=%b, expected 0 0 0 1 0", k, rv[k], rd[k], re[k], busy[k], ready[k]);
         end
      end
      @(posedge clk);
      #1 rst = 1;
      count_busy(c[0], c[1]);
      @(negedge clk) clr_req = 1;
      @(posedge clk);
      #1 clr_req = 0;
      @(negedge clk);
      @(negedge clk) rst = 0;
      @(posedge clk);
      #1 rst = 1;
      count_busy(c[0], c[1]);
      zero_model();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (c[k] !== 4) begin
            errors++;
            $display("FAIL reset_mid_sweep dut%0d: busy cycles %0d, expected 4", k, c[k]);
         end
      end
      issue(0, 2, 12, 0);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (got_v[k] !== 1 || got_e[k] !== 0 || got_d[k] !== 0) begin
            errors++;
            $display("FAIL read_after_reset dut%0d: v=%b e=%b d=%h, expected 1 0 00000000", k, got_v[k], got_e[k], got_d[k]);
         end
      end
      req_valid = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_errors();
      test_random();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
